mem_tcm: RTL and testbench
==========================

Name: mem_tcm

Overview:
Parametrised tightly-coupled memory that replaces the fixed single-cycle data/instruction memories on the core's memory interface. It adds a request/grant handshake, configurable wait states, address range checking against a base address, and a response for every granted request, including writes. One instance sits on the core data port and another on the instruction port, both inside the core top level.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words.
DATA_WIDTH, 32, word width; must be a multiple of 8.
WAIT_STATES, 0, extra cycles between grant and response, legal range 0..7.
BASE_ADDR, 32'h0000_0000, byte base address of the memory window; aligned to the window size.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_i  input  1  request; held high until gnt_o
gnt_o  output  1  request accepted this cycle
addr_i  input  32  byte address
we_i  input  1  1 = write, 0 = read
be_i  input  DATA_WIDTH/8  byte enables (writes only)
wdata_i  input  DATA_WIDTH  write data
rvalid_o  output  1  response valid, one-cycle pulse
rdata_o  output  DATA_WIDTH  read data, valid with rvalid_o
err_o  output  1  out-of-range access, valid with rvalid_o

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low. Outputs reset to gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0. The FSM resets to IDLE and the wait counter to 0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: gnt_o = req_i, combinational.
  - On grant, latch we_i, be_i, wdata_i, word index addr_i[ADDR_WIDTH+1:2], and the range flag.
  - Range flag: in range when (addr_i - BASE_ADDR) < 4*2**ADDR_WIDTH, computed as an unsigned 32-bit subtraction. Addresses below BASE_ADDR wrap to large values and are therefore out of range.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- WAIT: counter counts from 0 to WAIT_STATES-1, then goes to RESP. gnt_o=0.
- RESP: rvalid_o=1 for exactly one cycle, then return to IDLE. gnt_o=0 in RESP, so at most one request is outstanding.
  - Latency from grant to rvalid_o is WAIT_STATES+1 cycles. Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- The memory array access happens on the cycle the FSM enters RESP.
  - Write: update only the bytes with be_i set. rdata_o=0.
  - Read: rdata_o = mem[index], registered so it is valid with rvalid_o.
- Out of range: no array write; rdata_o=0, err_o=1. An in-range access gives err_o=0.
- be_i=0 on a write: no array change; a normal response with err_o=0.
- addr_i[1:0] is ignored, so all accesses are word-aligned.
- Write-then-read to the same address back to back: the read returns the new data. This holds naturally because the write commits before the next grant.
- Changes to req_i or other inputs during WAIT or RESP are ignored.
- Reset during WAIT or RESP: the FSM aborts to IDLE and no response is produced. A write already committed stays committed; a pending write whose commit cycle has not been reached is dropped.

Optional Feature:
MEM_TCM_STATS_EN
- Defined: adds output ports rd_cnt_o[31:0], wr_cnt_o[31:0] and err_cnt_o[15:0], plus input clr_cnt_i.
  - Counters increment on the RESP cycle by type: read, write, or out-of-range. An out-of-range access counts only in err_cnt_o.
  - Counters saturate at all-ones and reset to 0.
  - clr_cnt_i clears the counters synchronously and takes priority over an increment in the same cycle.
- Undefined: these ports and counters do not exist, and the behaviour is otherwise identical.

Decomposition:
- Package mem_tcm_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} tcm_state_e;
  - localparam WAIT_CNT_W = 3;
  - function in_range(addr, base, aw).
- Sub-module mem_tcm_array: a byte-enable write, synchronous-read RAM (ADDR_WIDTH, DATA_WIDTH) isolated for later SRAM-macro swap. The FSM stays in mem_tcm.

Test Plan:
1. WAIT_STATES=0: write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10. Required: gnt the same cycle as req, rvalid 1 cycle after grant, rdata=32'hDEADBEEF, err=0.
2. WAIT_STATES=3: read while holding req high continuously. Required: rvalid 4 cycles after grant, next gnt the cycle after rvalid, two requests spaced 5 cycles.
3. Byte enables: write 32'h11223344 to 0x20, then write 32'hAABBCCDD with be=4'b0101, then read 0x20. Required: rdata=32'h11BB33DD.
4. BASE_ADDR=32'h1000, ADDR_WIDTH=10: accesses to 0x0FFC and 0x2000 give err=1 and rdata=0, with memory unchanged. An access to 0x1FFC gives err=0.
5. Reset mid-operation: WAIT_STATES=5, assert rst_n low 2 cycles after grant. Required: no rvalid, outputs 0, and the next request is served normally.
6. MEM_TCM_STATS_EN: 3 reads, 2 writes and 1 out-of-range access give rd=3, wr=2, err=1. Asserting clr_cnt_i on the same cycle as a RESP gives all counters 0.

Source files
------------

// File: rtl/mem_tcm_pkg.sv
// Shared types and helpers for the tightly-coupled memory.
// The range check is a wrap-around unsigned offset compare against the window size.
package mem_tcm_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} tcm_state_e;

  localparam int WAIT_CNT_W = 3;

  // 33-bit limit so a window of 2**30 words still compares correctly
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base, input int aw);
    logic [31:0] off;
    logic [32:0] lim;
    off = addr - base;
    lim = 33'd4 << aw;
    return ({1'b0, off} < lim);
  endfunction

endpackage

// File: rtl/mem_tcm_array.sv
// Byte-enable write, synchronous-read RAM kept separate so it can become an SRAM macro.
// One access per enabled cycle; read data appears the cycle after en_i.
module mem_tcm_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb rdata_d = en_i ? mem_q[addr_i] : rdata_q;

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en_i && we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_tcm.sv
// Request/grant TCM with WAIT_STATES wait cycles, base-address range check and a response per grant.
// Optional access counters are built when MEM_TCM_STATS_EN is defined.
module mem_tcm
  import mem_tcm_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          DATA_WIDTH  = 32,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [31:0]             addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o
`ifdef MEM_TCM_STATS_EN
  ,
  input  logic                    clr_cnt_i,
  output logic [31:0]             rd_cnt_o,
  output logic [31:0]             wr_cnt_o,
  output logic [15:0]             err_cnt_o
`endif
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [WAIT_CNT_W-1:0] WS_LAST = WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  tcm_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    we_q, we_d, inr_q, inr_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [NB-1:0]           be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    grant, enter_resp, live, addr_inr;
  logic [DATA_WIDTH-1:0]   arr_rdata;

  assign addr_inr = in_range(addr_i, BASE_ADDR, ADDR_WIDTH);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    inr_d      = inr_q;
    idx_d      = idx_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    grant      = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (req_i) begin
        grant   = 1'b1;
        we_d    = we_i;
        inr_d   = addr_inr;
        idx_d   = addr_i[ADDR_WIDTH+1:2];
        be_d    = be_i;
        wdata_d = wdata_i;
        if (WAIT_STATES > 0) begin
          state_d = WAIT;
        end else begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      WAIT: if (cnt_q == WS_LAST) begin
        cnt_d      = '0;
        state_d    = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      inr_q   <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      inr_q   <= inr_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // With no wait states the array is accessed on the grant edge, so it takes the live inputs
  assign live = (state_q == IDLE);

  mem_tcm_array #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_array (
    .clk     (clk),
    .en_i    (enter_resp && (live ? addr_inr : inr_q)),
    .we_i    (live ? we_i : we_q),
    .addr_i  (live ? addr_i[ADDR_WIDTH+1:2] : idx_q),
    .be_i    (live ? be_i : be_q),
    .wdata_i (live ? wdata_i : wdata_q),
    .rdata_o (arr_rdata)
  );

  assign gnt_o    = grant;
  assign rvalid_o = (state_q == RESP);
  assign err_o    = (state_q == RESP) && !inr_q;
  assign rdata_o  = ((state_q == RESP) && !we_q && inr_q) ? arr_rdata : '0;

`ifdef MEM_TCM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr_cnt_i) begin
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
      err_cnt_d = '0;
    end else if (state_q == RESP) begin
      if (!inr_q)    err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
      else if (we_q) wr_cnt_d  = (&wr_cnt_q)  ? wr_cnt_q  : wr_cnt_q + 1'b1;
      else           rd_cnt_d  = (&rd_cnt_q)  ? rd_cnt_q  : rd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_cnt_o  = rd_cnt_q;
  assign wr_cnt_o  = wr_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_tcm.sv
// Three TCM instances (0, 3 and 5 wait states) driven by one sequential stimulus thread
// and checked every cycle against a word-array model of the memory window.
module tb_mem_tcm;

  localparam int          WS   [3] = '{0, 3, 5};
  localparam int          AW   [3] = '{10, 10, 6};
  localparam logic [31:0] BASE [3] = '{32'h0, 32'h1000, 32'h0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req [3], gnt [3], we [3], rvalid [3], err [3];
  logic [31:0] addr [3], wdata [3], rdata [3];
  logic [3:0]  be [3];
`ifdef MEM_TCM_STATS_EN
  logic        clr [3];
  logic [31:0] rdcnt [3], wrcnt [3];
  logic [15:0] ercnt [3];
`endif

  mem_tcm #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
    .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0])
`ifdef MEM_TCM_STATS_EN
    , .clr_cnt_i(clr[0]), .rd_cnt_o(rdcnt[0]), .wr_cnt_o(wrcnt[0]), .err_cnt_o(ercnt[0])
`endif
  );
  mem_tcm #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(3), .BASE_ADDR(32'h1000)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
    .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1])
`ifdef MEM_TCM_STATS_EN
    , .clr_cnt_i(clr[1]), .rd_cnt_o(rdcnt[1]), .wr_cnt_o(wrcnt[1]), .err_cnt_o(ercnt[1])
`endif
  );
  mem_tcm #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .WAIT_STATES(5), .BASE_ADDR(32'h0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
    .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2])
`ifdef MEM_TCM_STATS_EN
    , .clr_cnt_i(clr[2]), .rd_cnt_o(rdcnt[2]), .wr_cnt_o(wrcnt[2]), .err_cnt_o(ercnt[2])
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          k;
    bit          we;
    int          idx;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          inr;
    int          g;
    int          due;
  } pend_t;

  pend_t       pend;
  bit          pend_vld = 1'b0;
  logic [31:0] mm [3][1024];
  int          rdc [3], wrc [3], erc [3];
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;
  int          last_g;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
    tests++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req_v, cyc);
    end
  endtask

  // Compare process: one outstanding access at most; the model says when and what must come back
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        chk("reset_gnt", gnt[k], 0);
        chk("reset_rvalid", rvalid[k], 0);
        chk("reset_rdata", rdata[k], 0);
        chk("reset_err", err[k], 0);
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (pend_vld && pend.k == k) begin
          chk("gnt_while_busy", gnt[k], 0);
          if (rvalid[k] || cyc >= pend.due) begin
            pend_t p;
            logic [31:0] exp_rd;
            p = pend;
            exp_rd = (!p.we && p.inr) ? mm[k][p.idx] : 32'h0;
            chk("rsp_cycle", cyc, p.due);
            chk("rvalid", rvalid[k], 1);
            chk("rdata", rdata[k], exp_rd);
            chk("err", err[k], !p.inr);
            last_rdata = rdata[k];
            last_err   = err[k];
            last_lat   = cyc - p.g;
            if (p.inr && p.we)
              for (int b = 0; b < 4; b++)
                if (p.be[b]) mm[k][p.idx][8*b +: 8] = p.wd[8*b +: 8];
            if (!p.inr)    erc[k]++;
            else if (p.we) wrc[k]++;
            else           rdc[k]++;
            pend_vld = 1'b0;
          end
        end else begin
          chk("no_rvalid", rvalid[k], 0);
        end
      end
    end
  end

  task automatic access(input int k, input bit w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input bit hold);
    int n;
    logic [31:0] off;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    n = 0;
    #1;
    while (!gnt[k] && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!gnt[k]) begin
      chk("gnt_timeout", gnt[k], 1);
      req[k] = 1'b0;
    end else begin
      last_g = cyc;
      @(posedge clk);
      #1;
      off        = a - BASE[k];
      pend.k     = k;
      pend.we    = w;
      pend.idx   = int'((a >> 2) & ((32'd1 << AW[k]) - 1));
      pend.be    = b;
      pend.wd    = d;
      pend.inr   = (64'(off) < (64'd4 << AW[k]));
      pend.g     = last_g;
      pend.due   = last_g + WS[k] + 1;
      pend_vld   = 1'b1;
      if (!hold) req[k] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int g1;
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      req[k] = 0; we[k] = 0; addr[k] = 0; be[k] = 0; wdata[k] = 0;
      rdc[k] = 0; wrc[k] = 0; erc[k] = 0;
`ifdef MEM_TCM_STATS_EN
      clr[k] = 0;
`endif
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Random traffic per instance over 16 words plus out-of-window addresses
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++)
        access(k, 1'b1, BASE[k] + 32'(4*i), 4'hF, $urandom, 1'b1);
      for (int i = 0; i < 60; i++) begin
        bit hold;
        hold = ($urandom_range(0, 1) == 1) && (i != 59);
        case ($urandom_range(0, 5))
          0:       a = BASE[k] - 32'd4;
          1:       a = BASE[k] + (32'd4 << AW[k]) + 32'(4 * $urandom_range(0, 15));
          default: a = BASE[k] + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        endcase
        access(k, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, hold);
        if (!hold) idle($urandom_range(0, 2));
      end
      idle(10);
    end

    // Zero wait states: write/read 0x10
    access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
    access(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    idle(3);
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);
    chk("t1_err", last_err, 0);
    chk("t1_latency", last_lat, 1);

    // Byte enables
    access(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b1);
    access(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b1);
    access(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 1'b1);
    access(0, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    idle(3);
    chk("t3_rdata", last_rdata, 32'h11BB33DD);

    // Three wait states, req held high
    access(1, 1'b0, 32'h1000, 4'h0, 32'h0, 1'b1);
    g1 = last_g;
    access(1, 1'b0, 32'h1004, 4'h0, 32'h0, 1'b0);
    chk("t2_latency", last_lat, 4);
    chk("t2_spacing", last_g - g1, 5);
    idle(8);

    // Window checks at base 0x1000
    access(1, 1'b1, 32'h1000, 4'hF, 32'h0BADCAFE, 1'b0);
    idle(6);
    access(1, 1'b1, 32'h2000, 4'hF, 32'h55555555, 1'b0);
    idle(6);
    chk("t4_err_hi", last_err, 1);
    access(1, 1'b0, 32'h0FFC, 4'h0, 32'h0, 1'b0);
    idle(6);
    chk("t4_err_lo", last_err, 1);
    chk("t4_rdata_lo", last_rdata, 0);
    access(1, 1'b0, 32'h1000, 4'h0, 32'h0, 1'b0);
    idle(6);
    chk("t4_unchanged", last_rdata, 32'h0BADCAFE);
    access(1, 1'b0, 32'h1FFC, 4'h0, 32'h0, 1'b0);
    idle(6);
    chk("t4_err_top", last_err, 0);

`ifdef MEM_TCM_STATS_EN
    for (int k = 0; k < 3; k++) begin
      chk("stat_rd", rdcnt[k], rdc[k]);
      chk("stat_wr", wrcnt[k], wrc[k]);
      chk("stat_err", ercnt[k], erc[k]);
    end
`endif

    // Reset two cycles after grant with five wait states: write must be dropped
    access(2, 1'b1, 32'h8, 4'hF, 32'hCAFEF00D, 1'b0);
    idle(8);
    access(2, 1'b1, 32'h8, 4'hF, 32'h12345678, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    pend_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin rdc[k] = 0; wrc[k] = 0; erc[k] = 0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    access(2, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0);
    idle(8);
    chk("t5_rdata", last_rdata, 32'hCAFEF00D);
    chk("t5_latency", last_lat, 6);

`ifdef MEM_TCM_STATS_EN
    @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    rdc[0] = 0; wrc[0] = 0; erc[0] = 0;
    for (int i = 0; i < 3; i++) access(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) access(0, 1'b1, 32'h40, 4'hF, 32'h1, 1'b0);
    access(0, 1'b1, 32'h4000, 4'hF, 32'h2, 1'b0);
    idle(3);
    chk("t6_rd", rdcnt[0], 3);
    chk("t6_wr", wrcnt[0], 2);
    chk("t6_err", ercnt[0], 1);
    access(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    clr[0] = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    rdc[0] = 0; wrc[0] = 0; erc[0] = 0;
    @(negedge clk);
    chk("t6_clr_rd", rdcnt[0], 0);
    chk("t6_clr_wr", wrcnt[0], 0);
    chk("t6_clr_err", ercnt[0], 0);
`endif

    idle(4);
    chk("no_outstanding", pend_vld, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
